// File: rtl/clock_divider_pkg.sv
// clock_divider_pkg
// Shared helpers for the multi-channel power-of-two divider.
//   clamp_sel : limits a requested tap to the top bit of the prescale counter
//   mask      : low-bit mask 2^(s+1)-1 covering taps s..0
//   tap_bit   : single-bit value 2^s, the pattern a tap shows on its rising edge
// Taps are carried as 5-bit indices into a 32-bit zero-extended counter, which
// covers every legal WIDTH (2..32) without per-instance index widths.
package clock_divider_pkg;

  localparam int unsigned EXT_W = 32;
  localparam int unsigned TAP_W = 5;

  typedef logic [EXT_W-1:0] ext_t;
  typedef logic [TAP_W-1:0] tap_t;

  function automatic ext_t clamp_sel(input ext_t sel, input int unsigned width);
    if (sel >= width) begin
      return ext_t'(width - 1);
    end
    return sel;
  endfunction

  // For s = 31 the shift yields 0, and 0 - 1 wraps to all-ones as intended.
  function automatic ext_t mask(input tap_t s);
    return (ext_t'(2) << s) - ext_t'(1);
  endfunction

  function automatic ext_t tap_bit(input tap_t s);
    return ext_t'(1) << s;
  endfunction

endpackage

// File: rtl/clock_divider_chan.sv
// clock_divider_chan
// One output channel: holds its tap register and produces the divided wave
// and the rising-edge strobe from the next prescale counter value.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   sel        : requested tap (sampled only when load is high)
//   c_next     : counter value that will be visible after this edge
//   en, clr    : count enable, synchronous clear (already resolved in c_next)
//   load       : tap reload (clear or counter roll-over)
//   div        : divided square wave, equal to cnt[sel_r] every cycle
//   stb        : one-cycle pulse in the first cycle div reads 1
module clock_divider_chan
  import clock_divider_pkg::*;
#(
  parameter int WIDTH = 28,
  parameter int SEL_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] c_next,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  output logic             div,
  output logic             stb
);

  logic [SEL_W-1:0] sel_r;
  logic [SEL_W-1:0] sel_eff;
  tap_t             tap;
  ext_t             c_ext;
  logic             div_next;
  logic             stb_next;

  // The tap in effect after this edge: a reload takes effect together with
  // the counter value it accompanies, so div never sees a half-applied change.
  always_comb begin
    sel_eff = sel_r;
    if (load) begin
      sel_eff = SEL_W'(clamp_sel(ext_t'(sel), WIDTH));
    end
  end

  always_comb begin
    tap      = tap_t'(sel_eff);
    c_ext    = ext_t'(c_next);
    div_next = c_ext[tap];
    // Bits s..0 equal 10..0 exactly once per period: the cycle bit s rises.
    stb_next = en & ~clr & ((c_ext & mask(tap)) == tap_bit(tap));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r <= '0;
      div   <= 1'b0;
      stb   <= 1'b0;
    end else begin
      sel_r <= sel_eff;
      div   <= div_next;
      stb   <= stb_next;
    end
  end

endmodule

// File: rtl/clock_divider_multi.sv
// clock_divider_multi
// Free-running prescale counter shared by NCH power-of-two divider channels.
// Each channel picks a counter tap at runtime; tap changes are deferred to the
// next counter roll-over (or applied at once on clr) so outputs never glitch.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable; low freezes counter and outputs
//   clr        : synchronous clear, priority over en
//   sel        : per-channel tap select, channel k at [k*SEL_W +: SEL_W]
//   cnt        : prescale counter value
//   div        : divided square waves
//   stb        : one-cycle strobes on rising edges of div
//   wrap       : one-cycle pulse when the counter rolls over to zero
module clock_divider_multi
  import clock_divider_pkg::*;
#(
  parameter int WIDTH = 28,
  parameter int NCH   = 4,
  parameter int SEL_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [NCH*SEL_W-1:0] sel,
  output logic [WIDTH-1:0]     cnt,
  output logic [NCH-1:0]       div,
  output logic [NCH-1:0]       stb,
  output logic                 wrap
);

  logic [WIDTH-1:0] c_next;
  logic             at_top;
  logic             load;
  logic             wrap_next;

  assign at_top    = &cnt;
  assign load      = clr | (en & at_top);
  assign wrap_next = en & ~clr & at_top;

  always_comb begin
    c_next = cnt;
    if (clr) begin
      c_next = '0;
    end else if (en) begin
      c_next = cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      cnt  <= c_next;
      wrap <= wrap_next;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    clock_divider_chan #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .sel    (sel[k*SEL_W +: SEL_W]),
      .c_next (c_next),
      .en     (en),
      .clr    (clr),
      .load   (load),
      .div    (div[k]),
      .stb    (stb[k])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
module tb_clock_divider_multi;

  localparam int WIDTH = 8;
  localparam int NCH   = 2;
  localparam int SEL_W = 5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic                 clr;
  logic [NCH*SEL_W-1:0] sel;
  logic [WIDTH-1:0]     cnt;
  logic [NCH-1:0]       div;
  logic [NCH-1:0]       stb;
  logic                 wrap;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0]     m_cnt;
  logic [2:0]     m_sel [NCH];
  logic [NCH-1:0] m_div;
  logic [NCH-1:0] m_stb;
  logic           m_wrap;

  always #5 clk = ~clk;

  clock_divider_multi #(
    .WIDTH (WIDTH),
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .sel   (sel),
    .cnt   (cnt),
    .div   (div),
    .stb   (stb),
    .wrap  (wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt  = '0;
    m_div  = '0;
    m_stb  = '0;
    m_wrap = 1'b0;
    for (int k = 0; k < NCH; k++) m_sel[k] = '0;
  endtask

  // Strobe is modelled as "div went 0 -> 1 while counting", independent of
  // any bit-pattern compare.
  task automatic model_step();
    logic [7:0] nxt;
    logic       ld;
    logic [4:0] f;
    logic       nd;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ld     = clr | (en & (m_cnt == 8'hFF));
    m_wrap = en & ~clr & (m_cnt == 8'hFF);
    nxt    = clr ? 8'h00 : (en ? m_cnt + 8'h01 : m_cnt);
    for (int k = 0; k < NCH; k++) begin
      f = sel[k*SEL_W +: SEL_W];
      if (ld) m_sel[k] = (f > 5'd7) ? 3'd7 : f[2:0];
      nd       = nxt[m_sel[k]];
      m_stb[k] = en & ~clr & nd & ~m_div[k];
      m_div[k] = nd;
    end
    m_cnt = nxt;
  endtask

  task automatic check_model();
    chk("model_cnt", cnt, m_cnt);
    chk("model_div", div, m_div);
    chk("model_stb", stb, m_stb);
    chk("model_wrap", wrap, m_wrap);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int stb_cnt;
    stb_cnt = 0;

    // reset and enable
    rst_n = 1'b1; en = 1'b0; clr = 1'b0; sel = {5'd1, 5'd0};
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cnt", cnt, 0);
    chk("rst_div", div, 0);
    chk("rst_stb", stb, 0);
    chk("rst_wrap", wrap, 0);
    ticks(2);
    rst_n = 1'b1;
    clr = 1'b1; en = 1'b1;
    tick();
    chk("clr_cnt", cnt, 0);
    clr = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("run_cnt", cnt, i);
      chk("s0_div", div[0], i[0]);
      chk("s0_stb", stb[0], i[0]);
      chk("s1_div", div[1], i[1]);
      chk("s1_stb", stb[1], i[1:0] == 2'd2);
    end

    // asynchronous reset mid-count
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_cnt", cnt, 0);
    chk("arst_div", div, 0);
    chk("arst_stb", stb, 0);
    tick();
    rst_n = 1'b1;

    // tap change deferred to wrap
    clr = 1'b1;
    tick();
    clr = 1'b0;
    ticks(8'h40);
    chk("tap_cnt40", cnt, 8'h40);
    sel = {5'd1, 5'd3};
    ticks(8'hBF);
    chk("tap_cntff", cnt, 8'hFF);
    chk("tap_old_div0", div[0], 1);
    tick();
    chk("tap_wrap", wrap, 1);
    chk("tap_wrap_cnt", cnt, 0);
    chk("tap_wrap_div", div, 0);
    chk("tap_wrap_stb", stb, 0);
    ticks(7);
    chk("tap_c7_stb0", stb[0], 0);
    chk("tap_c7_div0", div[0], 0);
    tick();
    chk("tap_c8_cnt", cnt, 8'h08);
    chk("tap_c8_stb0", stb[0], 1);
    chk("tap_c8_div0", div[0], 1);
    ticks(16);
    chk("tap_c18_cnt", cnt, 8'h18);
    chk("tap_c18_stb0", stb[0], 1);

    // clamp: 31 behaves as tap 7
    sel = {5'd1, 5'd31};
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      tick();
      chk("clamp_div0", div[0], (i % 256) >= 128);
      chk("clamp_stb0", stb[0], (i % 256) == 128);
      if (stb[0]) stb_cnt++;
    end
    chk("clamp_stb_count", stb_cnt, 1);

    // freeze with en low
    ticks(8'h13);
    chk("frz_cnt", cnt, 8'h13);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("frz_hold_cnt", cnt, 8'h13);
      chk("frz_hold_div", div, 2'b10);
      chk("frz_stb", stb, 0);
      chk("frz_wrap", wrap, 0);
    end
    en = 1'b1;
    tick();
    chk("frz_resume_cnt", cnt, 8'h14);
    chk("frz_resume_div", div, 2'b00);

    // clear while en low
    en = 1'b0; clr = 1'b1;
    tick();
    chk("clr_noen_cnt", cnt, 0);
    clr = 1'b0; en = 1'b1;

    // simultaneous clr and wrap
    ticks(255);
    chk("cw_cntff", cnt, 8'hFF);
    sel = {5'd2, 5'd4};
    clr = 1'b1;
    tick();
    chk("cw_cnt", cnt, 0);
    chk("cw_wrap", wrap, 0);
    chk("cw_stb", stb, 0);
    chk("cw_div", div, 0);
    clr = 1'b0;
    ticks(4);
    chk("cw_c4_stb1", stb[1], 1);
    chk("cw_c4_stb0", stb[0], 0);
    ticks(12);
    chk("cw_c10_stb0", stb[0], 1);
    chk("cw_c10_div0", div[0], 1);
    chk("cw_c10_stb1", stb[1], 0);

    // random scoreboard
    for (int i = 0; i < 768; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 15) == 0) sel = 10'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
